// File: rtl/bsg_vanilla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_vanilla_pkg
//  Brief    : Shared types and defaults for the fpu_float issue controller.
//  Revision : 1.0
// ============================================================================
package bsg_vanilla_pkg;

    localparam int fpu_issue_starve_limit_gp = 4;
    localparam int fpu_issue_rd_width_gp     = 5;

    // Stage-1 occupancy record; stage 2 uses only v and rd (always FP).
    typedef struct packed {
        logic                             v;
        logic                             is_imul;
        logic [fpu_issue_rd_width_gp-1:0] rd;
    } fpu_issue_stage_s;

endpackage
`default_nettype wire

// File: rtl/fpu_float_issue_arb.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_float_issue_arb
//  Brief    : FP-priority two-requester arbiter with imul starvation override.
//  Revision : 1.0
// ============================================================================
module fpu_float_issue_arb
    import bsg_vanilla_pkg::*;
#(
    parameter int starve_limit_p = fpu_issue_starve_limit_gp
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic imul_req_i,
    input  logic fp_req_i,
    input  logic issue_en_i,
    output logic imul_grant_o,
    output logic fp_grant_o
);

    localparam logic [3:0] c_starve_limit = 4'(starve_limit_p);
    localparam logic [3:0] c_starve_max   = 4'hF;

    logic [3:0] r_starve;
    logic       w_imul_pri;

    assign w_imul_pri = (r_starve >= c_starve_limit);

    // Grants are forced low while reset is held, independent of the clock.
    assign imul_grant_o = reset_n_i & issue_en_i & imul_req_i & (~fp_req_i | w_imul_pri);
    assign fp_grant_o   = reset_n_i & issue_en_i & fp_req_i & ~(imul_req_i & w_imul_pri);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_starve <= '0;
        end else if (!imul_req_i || imul_grant_o) begin
            r_starve <= '0;
        end else if (issue_en_i && (r_starve != c_starve_max)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_float_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_float_issue_ctrl
//  Brief    : Issue, stall and hazard tracking for the two-stage fpu_float.
//  Revision : 1.0
// ============================================================================
module fpu_float_issue_ctrl
    import bsg_vanilla_pkg::*;
#(
    parameter int reg_addr_width_p = 5,
    parameter int starve_limit_p   = fpu_issue_starve_limit_gp,
    parameter int perf_width_p     = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        imul_req_i,
    input  logic [reg_addr_width_p-1:0] imul_rd_i,
    output logic                        imul_grant_o,
    input  logic                        fp_req_i,
    input  logic [reg_addr_width_p-1:0] fp_rd_i,
    output logic                        fp_grant_o,
    input  logic                        int_wb_ready_i,
    input  logic                        fp_wb_ready_i,
    output logic                        stall_fpu1_o,
    output logic                        stall_fpu2_o,
    output logic                        s1_v_o,
    output logic                        s1_is_imul_o,
    output logic [reg_addr_width_p-1:0] s1_rd_o,
    output logic [reg_addr_width_p-1:0] s2_rd_o,
    output logic                        s2_v_o,
    input  logic [reg_addr_width_p-1:0] chk_rd_i,
    input  logic                        chk_is_fp_i,
    output logic                        chk_hit_o,
    output logic                        idle_o,
    output logic [perf_width_p-1:0]     contention_cnt_o
);

    logic                        r_s1_v;
    logic                        r_s1_is_imul;
    logic [reg_addr_width_p-1:0] r_s1_rd;
    logic                        r_s2_v;
    logic [reg_addr_width_p-1:0] r_s2_rd;
    logic [perf_width_p-1:0]     r_contention;

    logic w_s1_done;
    logic w_issue_en;
    logic w_s2_move;
    logic w_s2_retire;
    logic w_s1_hit;
    logic w_s2_hit;
    logic w_int_x0;

    assign stall_fpu2_o = r_s2_v & ~fp_wb_ready_i;
    assign w_s1_done    = r_s1_is_imul ? int_wb_ready_i : ~stall_fpu2_o;
    assign stall_fpu1_o = r_s1_v & ~w_s1_done;
    assign w_issue_en   = ~stall_fpu1_o;

    fpu_float_issue_arb #(
        .starve_limit_p (starve_limit_p)
    ) u_arb (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .imul_req_i   (imul_req_i),
        .fp_req_i     (fp_req_i),
        .issue_en_i   (w_issue_en),
        .imul_grant_o (imul_grant_o),
        .fp_grant_o   (fp_grant_o)
    );

    // imul results leave from stage 1; only FP ops advance into stage 2.
    assign w_s2_move   = r_s1_v & ~r_s1_is_imul & w_s1_done;
    assign w_s2_retire = r_s2_v & fp_wb_ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_s1_v       <= 1'b0;
            r_s1_is_imul <= 1'b0;
            r_s1_rd      <= '0;
            r_s2_v       <= 1'b0;
            r_s2_rd      <= '0;
        end else begin
            if (imul_grant_o || fp_grant_o) begin
                r_s1_v       <= 1'b1;
                r_s1_is_imul <= imul_grant_o;
                r_s1_rd      <= imul_grant_o ? imul_rd_i : fp_rd_i;
            end else if (w_s1_done) begin
                r_s1_v       <= 1'b0;
                r_s1_is_imul <= 1'b0;
            end

            if (w_s2_move) begin
                r_s2_v  <= 1'b1;
                r_s2_rd <= r_s1_rd;
            end else if (w_s2_retire) begin
                r_s2_v  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_contention <= '0;
        end else if (imul_req_i && fp_req_i && w_issue_en && (r_contention != '1)) begin
            r_contention <= r_contention + perf_width_p'(1);
        end
    end

    // Integer x0 is hardwired, so a pending write to it is never a hazard.
    assign w_s1_hit  = r_s1_v & (r_s1_rd == chk_rd_i) & (r_s1_is_imul == ~chk_is_fp_i);
    assign w_s2_hit  = r_s2_v & (r_s2_rd == chk_rd_i) & chk_is_fp_i;
    assign w_int_x0  = ~chk_is_fp_i & (chk_rd_i == '0);
    assign chk_hit_o = (w_s1_hit | w_s2_hit) & ~w_int_x0;

    assign idle_o           = ~r_s1_v & ~r_s2_v;
    assign s1_v_o           = r_s1_v;
    assign s1_is_imul_o     = r_s1_is_imul;
    assign s1_rd_o          = r_s1_rd;
    assign s2_v_o           = r_s2_v;
    assign s2_rd_o          = r_s2_rd;
    assign contention_cnt_o = r_contention;

endmodule
`default_nettype wire

// File: tb/tb_fpu_float_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_float_issue_ctrl
//  Brief    : Directed scoreboard bench for fpu_float_issue_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_fpu_float_issue_ctrl;

    localparam int W = 5;
    localparam int P = 16;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         imul_req_i;
    logic [W-1:0] imul_rd_i;
    logic         imul_grant_o;
    logic         fp_req_i;
    logic [W-1:0] fp_rd_i;
    logic         fp_grant_o;
    logic         int_wb_ready_i;
    logic         fp_wb_ready_i;
    logic         stall_fpu1_o;
    logic         stall_fpu2_o;
    logic         s1_v_o;
    logic         s1_is_imul_o;
    logic [W-1:0] s1_rd_o;
    logic [W-1:0] s2_rd_o;
    logic         s2_v_o;
    logic [W-1:0] chk_rd_i;
    logic         chk_is_fp_i;
    logic         chk_hit_o;
    logic         idle_o;
    logic [P-1:0] contention_cnt_o;

    fpu_float_issue_ctrl #(
        .reg_addr_width_p (W),
        .starve_limit_p   (4),
        .perf_width_p     (P)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .imul_req_i       (imul_req_i),
        .imul_rd_i        (imul_rd_i),
        .imul_grant_o     (imul_grant_o),
        .fp_req_i         (fp_req_i),
        .fp_rd_i          (fp_rd_i),
        .fp_grant_o       (fp_grant_o),
        .int_wb_ready_i   (int_wb_ready_i),
        .fp_wb_ready_i    (fp_wb_ready_i),
        .stall_fpu1_o     (stall_fpu1_o),
        .stall_fpu2_o     (stall_fpu2_o),
        .s1_v_o           (s1_v_o),
        .s1_is_imul_o     (s1_is_imul_o),
        .s1_rd_o          (s1_rd_o),
        .s2_rd_o          (s2_rd_o),
        .s2_v_o           (s2_v_o),
        .chk_rd_i         (chk_rd_i),
        .chk_is_fp_i      (chk_is_fp_i),
        .chk_hit_o        (chk_hit_o),
        .idle_o           (idle_o),
        .contention_cnt_o (contention_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] int_q[$];
    logic [W-1:0] fp_q[$];
    logic [W-1:0] mon_int_exp;
    logic [W-1:0] mon_fp_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [W-1:0] ird, input logic fr,
                         input logic [W-1:0] frd, input logic irdy, input logic frdy);
        imul_req_i     = ir;
        imul_rd_i      = ird;
        fp_req_i       = fr;
        fp_rd_i        = frd;
        int_wb_ready_i = irdy;
        fp_wb_ready_i  = frdy;
    endtask

    // Expected grants; a granted op's rd becomes an expected retirement.
    task automatic grants(input logic ei, input logic ef);
        chk("imul_grant", imul_grant_o, ei);
        chk("fp_grant", fp_grant_o, ef);
        if (ei) int_q.push_back(imul_rd_i);
        if (ef) fp_q.push_back(fp_rd_i);
    endtask

    task automatic hazard(input logic [W-1:0] rd, input logic is_fp, input logic exp);
        chk_rd_i    = rd;
        chk_is_fp_i = is_fp;
        #1;
        chk("chk_hit", chk_hit_o, exp);
    endtask

    task automatic sample;
        @(negedge clk_i);
    endtask

    task automatic next;
        @(posedge clk_i);
        #1;
    endtask

    // Retirement monitor: imul leaves stage 1, FP leaves stage 2.
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            if (s1_v_o && s1_is_imul_o && int_wb_ready_i) begin
                if (int_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL int_retire: unexpected rd %0d, none expected", s1_rd_o);
                end else begin
                    mon_int_exp = int_q.pop_front();
                    chk("int_retire_rd", s1_rd_o, mon_int_exp);
                end
            end
            if (s2_v_o && fp_wb_ready_i) begin
                if (fp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fp_retire: unexpected rd %0d, none expected", s2_rd_o);
                end else begin
                    mon_fp_exp = fp_q.pop_front();
                    chk("fp_retire_rd", s2_rd_o, mon_fp_exp);
                end
            end
        end
    end

    initial begin
        reset_n_i   = 1'b0;
        chk_rd_i    = '0;
        chk_is_fp_i = 1'b1;
        drive(1, 1, 1, 2, 1, 1);
        sample;
        grants(0, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_stall1", stall_fpu1_o, 0);
        chk("rst_stall2", stall_fpu2_o, 0);
        chk("rst_cnt", contention_cnt_o, 0);
        hazard(0, 1, 0);
        next;
        reset_n_i = 1'b1;
        drive(0, 0, 0, 0, 1, 1);
        next;

        // Single FP op to f7
        drive(0, 0, 1, 7, 1, 1);
        sample; grants(0, 1); chk("t1_idle_n", idle_o, 1);
        next;
        drive(0, 0, 0, 0, 1, 1);
        sample;
        chk("t1_s1_v", s1_v_o, 1); chk("t1_s1_rd", s1_rd_o, 7);
        chk("t1_s1_imul", s1_is_imul_o, 0); chk("t1_s2_v", s2_v_o, 0);
        next;
        sample; chk("t1_s1_v2", s1_v_o, 0); chk("t1_s2_v2", s2_v_o, 1); chk("t1_s2_rd", s2_rd_o, 7);
        next;
        sample; chk("t1_idle", idle_o, 1);
        next;

        // Both requesting: four FP grants, then imul on the fifth
        for (int i = 0; i < 5; i++) begin
            drive(1, 3, 1, W'(10 + i), 1, 1);
            sample;
            grants(i == 4, i != 4);
            next;
        end
        drive(0, 0, 1, 14, 1, 1);
        sample; grants(0, 1); chk("t2_cnt", contention_cnt_o, 5);
        next;
        drive(1, 5, 1, 15, 1, 1);
        sample; grants(0, 1);
        next;

        // FP writeback backpressure with both stages full
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 1, 16, 1, 0);
            sample;
            grants(0, 0);
            chk("t3_stall1", stall_fpu1_o, 1);
            chk("t3_stall2", stall_fpu2_o, 1);
            chk("t3_cnt", contention_cnt_o, 6);
            next;
        end
        drive(1, 5, 1, 16, 1, 1);
        sample; grants(0, 1); chk("t3_stall1_clr", stall_fpu1_o, 0);
        next;
        drive(1, 5, 0, 0, 1, 1);
        sample; grants(1, 0); chk("t3_cnt2", contention_cnt_o, 7);
        next;

        // imul blocked in stage 1 while stage 2 drains
        drive(0, 0, 1, 20, 0, 1);
        sample;
        grants(0, 0);
        chk("t4_stall1", stall_fpu1_o, 1); chk("t4_stall2", stall_fpu2_o, 0);
        chk("t4_s1_imul", s1_is_imul_o, 1); chk("t4_s1_rd", s1_rd_o, 5);
        hazard(5, 0, 1);
        hazard(5, 1, 0);
        hazard(16, 1, 1);
        next;
        sample; grants(0, 0); chk("t4_s2_v", s2_v_o, 0); chk("t4_stall1b", stall_fpu1_o, 1);
        next;
        drive(0, 0, 1, 20, 1, 1);
        sample; grants(0, 1);
        next;

        // imul to x0 occupies the slot but never reports a hazard
        drive(1, 0, 0, 0, 1, 1);
        sample; grants(1, 0);
        next;
        drive(0, 0, 1, 21, 1, 1);
        sample;
        chk("t5_s1_v", s1_v_o, 1); chk("t5_s1_imul", s1_is_imul_o, 1); chk("t5_s1_rd", s1_rd_o, 0);
        hazard(0, 0, 0);
        hazard(20, 1, 1);
        grants(0, 1);
        next;
        drive(0, 0, 1, 22, 1, 1);
        sample; grants(0, 1);
        next;

        // Asynchronous reset with both stages occupied
        drive(1, 4, 1, 23, 1, 0);
        sample;
        chk("t6_pre_s1", s1_v_o, 1); chk("t6_pre_s2", s2_v_o, 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("t6_s1_v", s1_v_o, 0); chk("t6_s2_v", s2_v_o, 0); chk("t6_idle", idle_o, 1);
        chk("t6_stall1", stall_fpu1_o, 0); chk("t6_stall2", stall_fpu2_o, 0);
        chk("t6_cnt", contention_cnt_o, 0);
        chk("t6_imul_g", imul_grant_o, 0); chk("t6_fp_g", fp_grant_o, 0);
        int_q.delete();
        fp_q.delete();
        next;
        sample; grants(0, 0);
        next;
        reset_n_i = 1'b1;

        // Fresh imul after reset
        drive(1, 9, 0, 0, 1, 1);
        sample; grants(1, 0); chk("t7_cnt", contention_cnt_o, 0);
        next;
        drive(0, 0, 0, 0, 1, 1);
        sample; chk("t7_s1_imul", s1_is_imul_o, 1); chk("t7_s1_rd", s1_rd_o, 9);
        next;
        sample;
        chk("t7_idle", idle_o, 1);
        chk("int_q_empty", int_q.size(), 0);
        chk("fp_q_empty", fp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
